// File: rtl/pass_detector.sv
// Obstacle pass detector: scores one pulse per obstacle that clears the car rows, flags a sticky crash.
// Optional PassCount output when PASS_DETECTOR_PASS_COUNT_EN is defined.
module pass_detector #(
   parameter logic [6:0] CAR_TOP    = 7'd100,
   parameter logic [6:0] CAR_BOTTOM = 7'd115
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic       FrameTick,
   input  logic       ObstacleValid,
   input  logic [6:0] ObstacleY,
   input  logic [1:0] ObstacleLane,
   input  logic [1:0] CarLane,
   input  logic       GameOver,
   output logic       ScorePulse,
   output logic       Crash
`ifdef PASS_DETECTOR_PASS_COUNT_EN
   ,
   output logic [7:0] PassCount
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      APPROACH,
      OVERLAP,
      SCORED,
      CLEARED,
      CRASHED,
      HALT
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic       r_score_pulse;
   logic       r_crash;
   logic [1:0] w_lane_eq;
   logic       w_lane_match;
   logic       w_above;
   logic       w_below;
   logic       w_hit;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane_eq
         assign w_lane_eq[gi] = ~(ObstacleLane[gi] ^ CarLane[gi]);
      end
   endgenerate

   // Rows above 119 fall out naturally as "below the car" since CAR_BOTTOM <= 119.
   assign w_lane_match = &w_lane_eq;
   assign w_above      = (ObstacleY < CAR_TOP);
   assign w_below      = (ObstacleY > CAR_BOTTOM);
   assign w_hit        = !w_above && !w_below && w_lane_match;

   always_comb begin
      w_state_next = r_state;
      if (GameOver && (r_state != CRASHED)) begin
         w_state_next = HALT;
      end else if (r_state == SCORED) begin
         w_state_next = CLEARED;
      end else if (FrameTick) begin
         unique case (r_state)
            IDLE: begin
               if (ObstacleValid) begin
                  w_state_next = w_above ? APPROACH : CLEARED;
               end
            end
            APPROACH: begin
               // Entering the car rows applies the overlap rules on the same tick.
               if (!ObstacleValid) begin
                  w_state_next = IDLE;
               end else if (!w_above) begin
                  if (w_hit) begin
                     w_state_next = CRASHED;
                  end else if (w_below) begin
                     w_state_next = SCORED;
                  end else begin
                     w_state_next = OVERLAP;
                  end
               end
            end
            OVERLAP: begin
               if (w_hit) begin
                  w_state_next = CRASHED;
               end else if (!ObstacleValid) begin
                  w_state_next = IDLE;
               end else if (w_below) begin
                  w_state_next = SCORED;
               end
            end
            CLEARED: begin
               if (!ObstacleValid) begin
                  w_state_next = IDLE;
               end else if (w_above) begin
                  w_state_next = APPROACH;
               end
            end
            default: w_state_next = r_state;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         r_state       <= IDLE;
         r_score_pulse <= 1'b0;
         r_crash       <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_score_pulse <= (w_state_next == SCORED);
         r_crash       <= r_crash | (w_state_next == CRASHED);
      end
   end

   assign ScorePulse = r_score_pulse;
   assign Crash      = r_crash;

`ifdef PASS_DETECTOR_PASS_COUNT_EN
   logic [7:0] r_pass_count;

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         r_pass_count <= 8'd0;
      end else if (r_score_pulse && (r_pass_count != 8'hFF)) begin
         r_pass_count <= r_pass_count + 8'd1;
      end
   end

   assign PassCount = r_pass_count;
`endif

endmodule

// File: tb/tb_pass_detector.sv
// Self-checking bench for pass_detector: directed vector table, hand sequences, randomized model compare.
module tb_pass_detector;

   localparam logic [6:0] TOP = 7'd100;
   localparam logic [6:0] BOT = 7'd115;

   logic       CLOCK_50 = 1'b0;
   logic       Reset, FrameTick, ObstacleValid, GameOver;
   logic [6:0] ObstacleY;
   logic [1:0] ObstacleLane, CarLane;
   logic       ScorePulse, Crash;
`ifdef PASS_DETECTOR_PASS_COUNT_EN
   logic [7:0] PassCount;
`endif

   pass_detector #(.CAR_TOP(TOP), .CAR_BOTTOM(BOT)) dut (
      .CLOCK_50     (CLOCK_50),
      .Reset        (Reset),
      .FrameTick    (FrameTick),
      .ObstacleValid(ObstacleValid),
      .ObstacleY    (ObstacleY),
      .ObstacleLane (ObstacleLane),
      .CarLane      (CarLane),
      .GameOver     (GameOver),
      .ScorePulse   (ScorePulse),
      .Crash        (Crash)
`ifdef PASS_DETECTOR_PASS_COUNT_EN
      ,
      .PassCount    (PassCount)
`endif
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic       rst, ft, v;
      logic [6:0] y;
      logic [1:0] ol, cl;
      logic       go, ep, ec;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: obstacle progress relative to the car, plus sticky outcomes.
   // phase 0 none, 1 above car, 2 alongside, 3 just passed, 4 already passed.
   int   m_phase;
   bit   m_crash, m_halt, m_pulse;
   int   m_count;

   function automatic void add(input logic rst, ft, v, input logic [6:0] y,
                               input logic [1:0] ol, cl, input logic go, ep, ec);
      vec_t r;
      r.rst = rst; r.ft = ft; r.v = v; r.y = y; r.ol = ol; r.cl = cl;
      r.go = go; r.ep = ep; r.ec = ec;
      tbl.push_back(r);
   endfunction

   task automatic drive(input logic rst, ft, v, input logic [6:0] y,
                        input logic [1:0] ol, cl, input logic go);
      Reset = rst; FrameTick = ft; ObstacleValid = v; ObstacleY = y;
      ObstacleLane = ol; CarLane = cl; GameOver = go;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s idx=%0d got=%0d want=%0d", nm, idx, act, exp);
      end
   endtask

   task automatic model_step(input logic rst, ft, v, input logic [6:0] y,
                             input logic [1:0] ol, cl, input logic go);
      bit pulse_new = 1'b0;
      bit hit = (y >= TOP) && (y <= BOT) && (ol == cl);
      if (rst) begin
         m_phase = 0; m_crash = 0; m_halt = 0; m_pulse = 0; m_count = 0;
         return;
      end
      if (m_pulse && m_count < 255) m_count++;
      if (m_crash || m_halt) begin
      end else if (go) begin
         m_halt = 1;
      end else if (m_phase == 3) begin
         m_phase = 4;
      end else if (ft) begin
         case (m_phase)
            0: if (v) m_phase = (y < TOP) ? 1 : 4;
            1: begin
               if (!v) m_phase = 0;
               else if (y >= TOP) begin
                  if (hit) m_crash = 1;
                  else if (y > BOT) begin m_phase = 3; pulse_new = 1; end
                  else m_phase = 2;
               end
            end
            2: begin
               if (hit) m_crash = 1;
               else if (!v) m_phase = 0;
               else if (y > BOT) begin m_phase = 3; pulse_new = 1; end
            end
            4: begin
               if (!v) m_phase = 0;
               else if (y < TOP) m_phase = 1;
            end
            default: ;
         endcase
      end
      m_pulse = pulse_new;
   endtask

   initial begin
      int pulses;
      Reset = 1'b1; FrameTick = 0; ObstacleValid = 0; ObstacleY = 0;
      ObstacleLane = 0; CarLane = 0; GameOver = 0;

      // reset state
      add(1,0,0,  0,0,0,0, 0,0);
      add(1,0,0,  0,0,0,0, 0,0);
      // clean pass
      add(0,1,1, 50,2,0,0, 0,0);
      add(0,0,1, 50,2,0,0, 0,0);
      add(0,1,1,100,2,0,0, 0,0);
      add(0,1,1,110,2,0,0, 0,0);
      add(0,1,1,116,2,0,0, 1,0);
      add(0,0,1,116,2,0,0, 0,0);
      add(0,1,1,116,2,0,0, 0,0);
      // collision
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,1,1, 90,1,1,0, 0,0);
      add(0,1,1,105,1,1,0, 0,1);
      add(0,1,1,116,1,1,0, 0,1);
      add(0,0,0,  0,1,1,0, 0,1);
      add(0,1,1, 20,1,1,0, 0,1);
      add(0,0,0,  0,0,0,1, 0,1);
      // mid-screen spawn
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,1,1,105,1,1,0, 0,0);
      add(0,1,1,110,1,1,0, 0,0);
      add(0,1,1,116,1,1,0, 0,0);
      add(0,1,1, 20,1,1,0, 0,0);
      add(0,1,1,116,1,1,0, 1,0);
      add(0,0,1,116,1,1,0, 0,0);
      // game over while alongside, then reset recovery
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,1,1, 50,2,0,0, 0,0);
      add(0,1,1,105,2,0,0, 0,0);
      add(0,0,1,105,2,0,1, 0,0);
      add(0,1,1,116,2,0,0, 0,0);
      add(0,1,1, 20,2,0,0, 0,0);
      add(0,1,1,116,2,0,0, 0,0);
      add(0,1,1,105,2,2,0, 0,0);
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,1,1, 50,2,0,0, 0,0);
      add(0,1,1,116,2,0,0, 1,0);
      // game over on the cycle the pulse is out
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,1,1, 50,3,0,0, 0,0);
      add(0,1,1,116,3,0,0, 1,0);
      add(0,0,1,116,3,0,1, 0,0);
      add(0,1,1, 20,3,0,0, 0,0);
      add(0,1,1,116,3,0,0, 0,0);
      // reset during the pulse wins over FrameTick
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,1,1, 50,2,0,0, 0,0);
      add(0,1,1,116,2,0,0, 1,0);
      add(1,1,1,116,2,0,0, 0,0);
      add(0,1,1,116,2,0,0, 0,0);
      add(0,1,1,117,2,0,0, 0,0);
      // obstacle vanishes while alongside
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,1,1, 50,2,0,0, 0,0);
      add(0,1,1,110,2,0,0, 0,0);
      add(0,1,0,110,2,0,0, 0,0);
      add(0,1,1,116,2,0,0, 0,0);
      add(0,1,1,117,2,0,0, 0,0);
      // Y beyond the last screen row
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,1,1, 50,1,0,0, 0,0);
      add(0,1,1,125,1,0,0, 1,0);
      // positions ignored without FrameTick
      add(1,0,0,  0,0,0,0, 0,0);
      add(0,0,1, 50,1,1,0, 0,0);
      add(0,0,1,105,1,1,0, 0,0);
      add(0,1,1,116,1,1,0, 0,0);
      add(0,1,1,110,1,1,0, 0,0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].ft, tbl[i].v, tbl[i].y, tbl[i].ol, tbl[i].cl, tbl[i].go);
         chk("vec_pulse", i, {7'd0, ScorePulse}, {7'd0, tbl[i].ep});
         chk("vec_crash", i, {7'd0, Crash}, {7'd0, tbl[i].ec});
         $display("vec %0d rst=%0b ft=%0b v=%0b y=%0d ol=%0d cl=%0d go=%0b -> pulse=%0b crash=%0b",
                  i, tbl[i].rst, tbl[i].ft, tbl[i].v, tbl[i].y, tbl[i].ol, tbl[i].cl,
                  tbl[i].go, ScorePulse, Crash);
      end

      // double-count guard
      pulses = 0;
      drive(1,0,0,0,0,0,0);
      drive(0,1,1, 50,2,0,0); pulses += int'(ScorePulse);
      drive(0,1,1,116,2,0,0); pulses += int'(ScorePulse);
      drive(0,0,1,116,2,0,0); pulses += int'(ScorePulse);
      for (int k = 0; k < 10; k++) begin
         drive(0,1,1,118,2,0,0); pulses += int'(ScorePulse);
         drive(0,0,1,118,2,0,0); pulses += int'(ScorePulse);
      end
      drive(0,1,1, 20,2,0,0); pulses += int'(ScorePulse);
      drive(0,1,1,116,2,0,0); pulses += int'(ScorePulse);
      chk("dbl_second_pulse", 0, {7'd0, ScorePulse}, 8'd1);
      for (int k = 0; k < 6; k++) begin
         drive(0,1,1,116,2,0,0); pulses += int'(ScorePulse);
      end
      chk("dbl_total", 0, pulses[7:0], 8'd2);
      $display("double-count guard: pulses=%0d", pulses);

`ifdef PASS_DETECTOR_PASS_COUNT_EN
      drive(1,0,0,0,0,0,0);
      chk("cnt_reset0", 0, PassCount, 8'd0);
      for (int k = 0; k < 300; k++) begin
         drive(0,1,1, 50,2,0,0);
         drive(0,1,1,116,2,0,0);
         drive(0,0,1,116,2,0,0);
         if (k == 9) chk("cnt_10", k, PassCount, 8'd10);
      end
      chk("cnt_sat", 0, PassCount, 8'd255);
      $display("pass count after 300 passes: %0d", PassCount);
      drive(1,0,0,0,0,0,0);
      chk("cnt_reset", 0, PassCount, 8'd0);
`endif

      // randomized comparison against the model
      drive(1,0,0,0,0,0,0);
      model_step(1,0,0,0,0,0,0);
      for (int k = 0; k < 4000; k++) begin
         logic       r_rst, r_ft, r_v, r_go;
         logic [6:0] r_y;
         logic [1:0] r_ol, r_cl;
         r_rst = ($urandom_range(0, 59) == 0);
         r_ft  = $urandom_range(0, 1) != 0;
         r_v   = ($urandom_range(0, 15) != 0);
         r_y   = 7'($urandom_range(0, 127));
         r_ol  = 2'($urandom_range(0, 3));
         r_cl  = 2'($urandom_range(0, 3));
         r_go  = ($urandom_range(0, 299) == 0);
         model_step(r_rst, r_ft, r_v, r_y, r_ol, r_cl, r_go);
         drive(r_rst, r_ft, r_v, r_y, r_ol, r_cl, r_go);
         chk("rnd_pulse", k, {7'd0, ScorePulse}, {7'd0, m_pulse});
         chk("rnd_crash", k, {7'd0, Crash}, {7'd0, m_crash});
`ifdef PASS_DETECTOR_PASS_COUNT_EN
         chk("rnd_count", k, PassCount, 8'(m_count));
`endif
      end
      $display("random phase: 4000 cycles compared");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
